dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in clock cycles; legal range 1..3.
REQ-004 clock  in  1  single clock; every flop rises on it.
REQ-005 clr  in  1  asynchronous, active-high reset.
REQ-006 a_req, b_req  in  1 each  access request from requester A (CPU) and requester B (secondary master).
REQ-007 a_we, b_we  in  1 each  1 = write, 0 = read; qualified by req.
REQ-008 a_addr, b_addr  in  AW each  byte address.
REQ-009 a_wdata, b_wdata  in  DW each  write data.
REQ-010 a_gnt, b_gnt  out  1 each  one-cycle grant; request captured.
REQ-011 a_rvalid, b_rvalid  out  1 each  one-cycle read-data-valid strobe.
REQ-012 a_rdata, b_rdata  out  DW each  read data; valid while the matching rvalid is high.
REQ-013 m_addr  out  AW  address to the shared memory/IO space.
REQ-014 m_datain  out  DW  write data to the shared space.
REQ-015 m_we  out  1  write enable to the shared space.
REQ-016 m_dataout  in  DW  read data from the shared space.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT.
REQ-018 IDLE with no request: stay in IDLE.
REQ-019 IDLE with a request: pick one owner; register owner, we, addr and wdata on that edge; next state ISSUE.
REQ-020 One requester active: that requester wins.
REQ-021 Both active: the requester not served last wins; the last-served pointer updates on every capture.
REQ-022 ISSUE lasts one cycle: drive m_addr/m_datain from the captured values; m_we = captured we; assert owner's gnt.
REQ-023 ISSUE with a write: next state IDLE.
REQ-024 ISSUE with a read: next state WAIT.
REQ-025 WAIT counts RD_LAT cycles; on the last, sample m_dataout into owner's rdata, pulse owner's rvalid on the following cycle, go IDLE.
REQ-026 m_we is 0 in every state except ISSUE.
REQ-027 m_addr and m_datain hold their last values outside ISSUE.
REQ-028 Each rdata holds its value until the next rvalid to that requester.
REQ-029 Requester holds req and operands stable until it samples gnt = 1; req still high on the edge after gnt counts as a new request.
REQ-030 Requests arriving outside IDLE wait; none are lost or merged.
REQ-031 gnt and rvalid are never high for both requesters in the same cycle.
REQ-032 Throughput limit: 1 write per 2 cycles; 1 read per (2 + RD_LAT) cycles.

Reset
REQ-033 clr high forces: state IDLE; all gnt, rvalid and m_we 0; m_addr, m_datain, rdata 0; last-served pointer = B, so A wins the first tie.
REQ-034 Reset mid-transaction discards the pending access; no rvalid is produced for it.

Configuration
REQ-035 Macro DMEM_ARB_LOCK_EN defined: add inputs a_lock, b_lock (1 bit each).
REQ-036 With the lock: if the owner's lock and req are high when its transaction completes, the next capture goes to the same owner regardless of round-robin.
REQ-037 The lock is forcibly released after LOCK_MAX = 8 consecutive grants.
REQ-038 Macro undefined: no lock ports, pure round-robin.

Structure
REQ-039 Package dmem_arb_pkg holds: the state encoding, the owner encoding (OWN_A, OWN_B), LOCK_MAX, and the RD_LAT legal-range constants.
REQ-040 Sub-module rr_pick2 is the combinational two-way round-robin picker (req_a, req_b, last -> win_valid, win).

Verification
REQ-041 Reset, then a_req=1, a_we=1, a_addr=0x10, a_wdata=0xDEADBEEF -> ISSUE next cycle: m_we=1, m_addr=0x10, m_datain=0xDEADBEEF, a_gnt=1; b_gnt stays 0.
REQ-042 RD_LAT=1, b_req read of 0x84 with m_dataout=0x00000055 -> b_gnt in ISSUE, b_rvalid=1 with b_rdata=0x55 exactly 3 cycles after capture, m_we=0 throughout.
REQ-043 a_req and b_req held high with writes -> grants alternate A,B,A,B; each requester gets exactly 2 grants in 8 cycles.
REQ-044 clr asserted in WAIT of an A read -> outputs zero immediately; no a_rvalid after release; next request is served normally.
REQ-045 DMEM_ARB_LOCK_EN defined, a_lock=1, both requesting writes -> 8 consecutive A grants, then B granted.
REQ-046 RD_LAT=3, back-to-back A reads -> gnt spacing of 5 cycles; each rvalid matches its own address's data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Consecutive grants a locking owner may take before it is forced to yield.
    localparam int LOCK_MAX   = 8;

    // Supported memory read latency, in clock cycles.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, the requester not served last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last,
    output logic   win_valid,
    output owner_t win
);

    // Single requester wins outright; a tie goes to whoever was not served last.
    always_comb begin
        win_valid = req_a | req_b;
        win       = OWN_A;
        if (req_a && req_b)
            win = (last == OWN_A) ? OWN_B : OWN_A;
        else if (req_b)
            win = OWN_B;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one data-memory port between requester A (CPU) and B.
// Optional feature: define DMEM_ARB_LOCK_EN to add a_lock/b_lock, letting the
// current owner keep the port for up to LOCK_MAX consecutive grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          clr,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          a_lock,
    input  logic          b_lock,
`endif
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_datain,
    output logic          m_we,
    input  logic [DW-1:0] m_dataout
);

    // Out-of-range latencies are clamped so the wait counter stays 2 bits wide.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [1:0] LAT_LAST = 2'(LAT - 1);

    state_t        state, state_nxt;
    owner_t        owner;          // current owner, doubles as last-served pointer
    owner_t        pick_win;
    owner_t        sel_own;
    logic          pick_valid;
    logic          capture;
    logic          rd_done;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [1:0]    wait_cnt;

    rr_pick2 u_pick (
        .req_a     (a_req),
        .req_b     (b_req),
        .last      (owner),
        .win_valid (pick_valid),
        .win       (pick_win)
    );

`ifdef DMEM_ARB_LOCK_EN
    logic [3:0] cons_cnt;   // consecutive captures by the same owner, saturating
    logic       lock_hold;  // owner finished while locked and still requesting
    logic       xact_done;
    logic       own_lock;
    logic       own_req;

    // A held lock overrides round-robin only while the owner is still asking.
    always_comb begin
        own_lock  = (owner == OWN_A) ? a_lock : b_lock;
        own_req   = (owner == OWN_A) ? a_req  : b_req;
        xact_done = ((state == ISSUE) && cap_we) || rd_done;
        sel_own   = (lock_hold && own_req) ? owner : pick_win;
    end

    // Track consecutive grants and latch the lock decision at transaction end.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            cons_cnt  <= 4'd0;
            lock_hold <= 1'b0;
        end else begin
            if (capture) begin
                if (sel_own != owner)
                    cons_cnt <= 4'd1;
                else if (cons_cnt < 4'(LOCK_MAX))
                    cons_cnt <= cons_cnt + 4'd1;
            end
            if (xact_done)
                lock_hold <= own_lock && own_req && (cons_cnt < 4'(LOCK_MAX));
            else if (capture)
                lock_hold <= 1'b0;
        end
    end
`else
    assign sel_own = pick_win;
`endif

    // State register.
    always_ff @(posedge clock or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and per-state strobes; memory write and grants only in ISSUE.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rd_done   = 1'b0;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        m_we      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_we      = cap_we;
                a_gnt     = (owner == OWN_A);
                b_gnt     = (owner == OWN_B);
                state_nxt = cap_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == LAT_LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner's operands, count read latency, return read data.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            owner     <= OWN_B;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            wait_cnt  <= 2'd0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (capture) begin
                owner     <= sel_own;
                cap_we    <= (sel_own == OWN_A) ? a_we    : b_we;
                cap_addr  <= (sel_own == OWN_A) ? a_addr  : b_addr;
                cap_wdata <= (sel_own == OWN_A) ? a_wdata : b_wdata;
                wait_cnt  <= 2'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            if (rd_done) begin
                if (owner == OWN_A) begin
                    a_rdata  <= m_dataout;
                    a_rvalid <= 1'b1;
                end else begin
                    b_rdata  <= m_dataout;
                    b_rvalid <= 1'b1;
                end
            end
        end
    end

    // Captured operands stay on the memory port until the next capture.
    assign m_addr   = cap_addr;
    assign m_datain = cap_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (RD_LAT=1 and RD_LAT=3 instances).
module tb_dmem_arbiter;

    logic        clock, clr;

    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, m_we;
    logic [31:0] a_rdata, b_rdata, m_addr, m_datain, m_dataout, mdata1;

    logic        a_req3, a_we3, b_req3, b_we3;
    logic [31:0] a_addr3, b_addr3, a_wdata3, b_wdata3;
    logic        a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, m_we3;
    logic [31:0] a_rdata3, b_rdata3, m_addr3, m_datain3, m_dataout3;

`ifdef DMEM_ARB_LOCK_EN
    logic        a_lock, b_lock, a_lock3, b_lock3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    assign m_dataout  = mdata1;
    assign m_dataout3 = m_addr3 ^ 32'hA5A5_0000;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut (
        .clock(clock), .clr(clr),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_datain(m_datain), .m_we(m_we), .m_dataout(m_dataout)
    );

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
        .clock(clock), .clr(clr),
        .a_req(a_req3), .a_we(a_we3), .a_addr(a_addr3), .a_wdata(a_wdata3),
        .b_req(b_req3), .b_we(b_we3), .b_addr(b_addr3), .b_wdata(b_wdata3),
`ifdef DMEM_ARB_LOCK_EN
        .a_lock(a_lock3), .b_lock(b_lock3),
`endif
        .a_gnt(a_gnt3), .b_gnt(b_gnt3), .a_rvalid(a_rvalid3), .b_rvalid(b_rvalid3),
        .a_rdata(a_rdata3), .b_rdata(b_rdata3),
        .m_addr(m_addr3), .m_datain(m_datain3), .m_we(m_we3), .m_dataout(m_dataout3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        a_req3 = 0; a_we3 = 0; a_addr3 = 0; a_wdata3 = 0;
        b_req3 = 0; b_we3 = 0; b_addr3 = 0; b_wdata3 = 0;
        mdata1 = 32'h0;
`ifdef DMEM_ARB_LOCK_EN
        a_lock = 0; b_lock = 0; a_lock3 = 0; b_lock3 = 0;
`endif
        tick(); tick();
        n_chk++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, m_we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b exp 00000", {a_gnt, b_gnt, a_rvalid, b_rvalid, m_we});
        end
        n_chk++;
        if ({m_addr, m_datain, a_rdata, b_rdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h exp zero", m_addr, m_datain, a_rdata, b_rdata);
        end
        clr = 1'b0;
        tick();
        n_chk++;
        if ({a_gnt, b_gnt, m_we} !== 3'b0) begin
            n_fail++; $display("FAIL idle_no_req: got %b exp 000", {a_gnt, b_gnt, m_we});
        end
    endtask

    task automatic test_write_a();
        a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
        tick();  // ISSUE
        n_chk++;
        if ({m_we, a_gnt, b_gnt} !== 3'b110) begin
            n_fail++; $display("FAIL wr_issue_strobes: got %b exp 110", {m_we, a_gnt, b_gnt});
        end
        n_chk++;
        if (m_addr !== 32'h10 || m_datain !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_issue_data: got %h %h exp 00000010 deadbeef", m_addr, m_datain);
        end
        a_req = 0;
        tick();  // back in IDLE
        n_chk++;
        if ({m_we, a_gnt} !== 2'b00 || m_addr !== 32'h10) begin
            n_fail++; $display("FAIL wr_after_hold: got we=%b gnt=%b addr=%h exp 0 0 00000010", m_we, a_gnt, m_addr);
        end
    endtask

    task automatic test_read_b();
        mdata1 = 32'h55;
        b_req = 1; b_we = 0; b_addr = 32'h84;
        tick();  // cycle 1: ISSUE
        n_chk++;
        if ({b_gnt, a_gnt, m_we, b_rvalid} !== 4'b1000 || m_addr !== 32'h84) begin
            n_fail++; $display("FAIL rd_issue: got gnt_b/a/we/rv=%b addr=%h exp 1000 00000084", {b_gnt, a_gnt, m_we, b_rvalid}, m_addr);
        end
        b_req = 0;
        tick();  // cycle 2: WAIT
        n_chk++;
        if ({b_rvalid, m_we, b_gnt} !== 3'b000) begin
            n_fail++; $display("FAIL rd_wait: got rv/we/gnt=%b exp 000", {b_rvalid, m_we, b_gnt});
        end
        tick();  // cycle 3: data returned
        n_chk++;
        if ({b_rvalid, a_rvalid, m_we} !== 3'b100 || b_rdata !== 32'h55) begin
            n_fail++; $display("FAIL rd_rvalid: got rv_b/a/we=%b data=%h exp 100 00000055", {b_rvalid, a_rvalid, m_we}, b_rdata);
        end
        mdata1 = 32'hFFFF_0000;
        tick();
        n_chk++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'h55) begin
            n_fail++; $display("FAIL rd_hold: got rv=%b data=%h exp 0 00000055", b_rvalid, b_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_a, exp_b;
        int na, nb;
        exp_a = 8'b0001_0001;
        exp_b = 8'b0100_0100;
        na = 0; nb = 0;
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h1111_1111;
        b_req = 1; b_we = 1; b_addr = 32'h30; b_wdata = 32'h2222_2222;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_gnt === 1'b1) na++;
            if (b_gnt === 1'b1) nb++;
            n_chk++;
            if (a_gnt !== exp_a[i] || b_gnt !== exp_b[i]) begin
                n_fail++; $display("FAIL rr_cycle%0d: got a=%b b=%b exp a=%b b=%b", i + 1, a_gnt, b_gnt, exp_a[i], exp_b[i]);
            end
            if (b_gnt === 1'b1) begin
                n_chk++;
                if (m_datain !== 32'h2222_2222 || m_addr !== 32'h30) begin
                    n_fail++; $display("FAIL rr_b_data: got %h %h exp 00000030 22222222", m_addr, m_datain);
                end
            end
            if (i == 7) begin a_req = 0; b_req = 0; end
        end
        n_chk++;
        if (na != 2 || nb != 2) begin
            n_fail++; $display("FAIL rr_counts: got a=%0d b=%0d exp 2 2", na, nb);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        mdata1 = 32'h77;
        a_req = 1; a_we = 0; a_addr = 32'h40;
        tick();  // ISSUE
        n_chk++;
        if (a_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_gnt: got %b exp 1", a_gnt);
        end
        a_req = 0;
        tick();  // WAIT
        clr = 1'b1;
        #1;
        n_chk++;
        if (m_addr !== 32'h0 || {a_gnt, m_we, a_rvalid} !== 3'b0 || a_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_async: got addr=%h strobes=%b rdata=%h exp zero", m_addr, {a_gnt, m_we, a_rvalid}, a_rdata);
        end
        tick();
        clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_rvalid === 1'b1) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_no_rvalid: got %0d strobes exp 0", seen);
        end
        mdata1 = 32'h99;
        a_req = 1; a_we = 0; a_addr = 32'h48;
        tick();
        n_chk++;
        if (a_gnt !== 1'b1 || m_addr !== 32'h48) begin
            n_fail++; $display("FAIL rst_after_gnt: got gnt=%b addr=%h exp 1 00000048", a_gnt, m_addr);
        end
        a_req = 0;
        tick(); tick();
        n_chk++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h99) begin
            n_fail++; $display("FAIL rst_after_data: got rv=%b data=%h exp 1 00000099", a_rvalid, a_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back_lat3();
        int g0, g1, ng, nr;
        logic [31:0] rd0, rd1;
        g0 = -1; g1 = -1; ng = 0; nr = 0; rd0 = 0; rd1 = 0;
        a_req3 = 1; a_we3 = 0; a_addr3 = 32'h100;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (a_rvalid3 === 1'b1) begin
                if (nr == 0) begin
                    rd0 = a_rdata3;
                    n_chk++;
                    if (c != 5) begin n_fail++; $display("FAIL lat3_rv0_cycle: got %0d exp 5", c); end
                end else begin
                    rd1 = a_rdata3;
                    n_chk++;
                    if (c != 10) begin n_fail++; $display("FAIL lat3_rv1_cycle: got %0d exp 10", c); end
                end
                nr++;
            end
            if (a_gnt3 === 1'b1) begin
                if (ng == 0) begin g0 = c; a_addr3 = 32'h204; end
                else begin g1 = c; a_req3 = 0; end
                ng++;
            end
        end
        n_chk++;
        if (g0 != 1 || g1 - g0 != 5) begin
            n_fail++; $display("FAIL lat3_gnt_spacing: got first=%0d gap=%0d exp 1 5", g0, g1 - g0);
        end
        n_chk++;
        if (nr != 2 || rd0 !== 32'hA5A5_0100 || rd1 !== 32'hA5A5_0204) begin
            n_fail++; $display("FAIL lat3_rdata: got n=%0d %h %h exp 2 a5a50100 a5a50204", nr, rd0, rd1);
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        int ng, first_b;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ng = 0; first_b = -1;
        a_lock = 1;
        a_req = 1; a_we = 1; a_addr = 32'h50; a_wdata = 32'hA;
        b_req = 1; b_we = 1; b_addr = 32'h60; b_wdata = 32'hB;
        for (int c = 0; c < 24 && first_b < 0; c++) begin
            tick();
            if (a_gnt === 1'b1) ng++;
            if (b_gnt === 1'b1) first_b = ng;
        end
        n_chk++;
        if (first_b != 8) begin
            n_fail++; $display("FAIL lock_run: got %0d A grants before B exp 8", first_b);
        end
        a_req = 0; b_req = 0; a_lock = 0;
        tick(); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_round_robin();
        test_reset_mid_read();
        test_back_to_back_lat3();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

endmodule
